melody_sequencer: RTL

//  Plays a stored song on one square-wave tone voice. Steps through a per-song note ROM

---
 rtl/melody_sequencer_if.sv | 18 +
 rtl/melody_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/melody_sequencer_if.sv
// Audio_Controller write handshake: sample strobe, signed sample and FIFO space flag.
interface melody_sequencer_if;
  logic               audio_out_allowed;
  logic               write_audio_out;
  logic signed [31:0] sample;

  modport master (
    input  audio_out_allowed,
    output write_audio_out,
    output sample
  );

  modport slave (
    output audio_out_allowed,
    input  write_audio_out,
    input  sample
  );
endinterface

// File: rtl/melody_sequencer.sv
// Single-voice square-wave song player: note ROM, beat/gap down-counters, tone phase.
// Optional tempo input is enabled with `define MELODY_SEQ_TEMPO_EN.
//
//   state | meaning
//   IDLE  | waiting for a valid start
//   LOAD  | fetch ROM entry at note_idx, handle end marker / loop
//   PLAY  | tone sounding, duration counter running
//   GAP   | silent tail of the note
//   DONE  | one-cycle done pulse, back to IDLE
module melody_sequencer #(
  parameter int unsigned BEAT_CYCLES = 50000000,
  parameter int unsigned GAP_CYCLES  = 2500000,
  parameter int unsigned AMPLITUDE   = 10000000,
  parameter logic [19:0] HP_OVERRIDE = 20'd0
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  input  logic [1:0]         song_sel,
  input  logic               start,
  input  logic               stop,
  input  logic               loop_en,
`ifdef MELODY_SEQ_TEMPO_EN
  input  logic [1:0]         tempo,
`endif
  melody_sequencer_if.master audio,
  output logic               busy,
  output logic               done,
  output logic [4:0]         note_idx,
  output logic [19:0]        half_period
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP, S_DONE} state_t;

  localparam logic signed [31:0] AMP_POS  = 32'(AMPLITUDE);
  localparam logic signed [31:0] AMP_NEG  = -AMP_POS;
  localparam logic [31:0]        BEAT     = 32'(BEAT_CYCLES);
  localparam logic [31:0]        BEAT_X2  = 32'(BEAT_CYCLES * 2);
  localparam logic [31:0]        BEAT_HLF = 32'(BEAT_CYCLES / 2);
  localparam logic [31:0]        GAP      = 32'(GAP_CYCLES);

  state_t             state, state_nx;
  logic [1:0]         song;
  logic [19:0]        tone_cnt;
  logic               phase;
  logic [31:0]        dur_cnt;
  logic [31:0]        gap_cnt;
  logic signed [31:0] sample_q;

  logic [5:0]  entry;
  logic [2:0]  code;
  logic [2:0]  beats;
  logic        is_end;
  logic        start_ok;
  logic [19:0] load_hp;
  logic [31:0] beat_len;
  logic [34:0] prod;
  logic [31:0] dur_load;

  // Entries are {code, beats}, written as two octal digits.
  function automatic logic [5:0] rom_entry(input logic [1:0] s, input logic [4:0] i);
    logic [5:0] e;
    e = 6'o00;
    if (s == 2'd1) begin
      case (i)
        5'd0, 5'd1:   e = 6'o11;
        5'd2, 5'd3:   e = 6'o51;
        5'd4, 5'd5:   e = 6'o61;
        5'd6:         e = 6'o52;
        5'd7, 5'd8:   e = 6'o41;
        5'd9, 5'd10:  e = 6'o31;
        5'd11, 5'd12: e = 6'o21;
        5'd13:        e = 6'o12;
        default:      e = 6'o00;
      endcase
    end else if (s == 2'd2) begin
      case (i)
        5'd0, 5'd3, 5'd14:            e = 6'o31;
        5'd1, 5'd4, 5'd15:            e = 6'o21;
        5'd2, 5'd5, 5'd16:            e = 6'o12;
        5'd6, 5'd7, 5'd8, 5'd9:       e = 6'o11;
        5'd10, 5'd11, 5'd12, 5'd13:   e = 6'o21;
        default:                      e = 6'o00;
      endcase
    end
    return e;
  endfunction

  function automatic logic [19:0] hp_of(input logic [2:0] c);
    logic [19:0] h;
    case (c)
      3'd1:    h = 20'd191114;
      3'd2:    h = 20'd170263;
      3'd3:    h = 20'd151687;
      3'd4:    h = 20'd143174;
      3'd5:    h = 20'd127554;
      3'd6:    h = 20'd113637;
      3'd7:    h = 20'd101239;
      default: h = 20'd0;
    endcase
    return h;
  endfunction

  always_comb begin
    entry    = rom_entry(song, note_idx);
    code     = entry[5:3];
    beats    = entry[2:0];
    is_end   = (entry == 6'o00);
    start_ok = start && !stop && (song_sel == 2'd1 || song_sel == 2'd2);
    if (code == 3'd0)
      load_hp = 20'd0;
    else if (HP_OVERRIDE != 20'd0)
      load_hp = HP_OVERRIDE;
    else
      load_hp = hp_of(code);
  end

  always_comb begin
`ifdef MELODY_SEQ_TEMPO_EN
    case (tempo)
      2'b01:   beat_len = BEAT_X2;
      2'b10:   beat_len = BEAT_HLF;
      default: beat_len = BEAT;
    endcase
`else
    beat_len = BEAT;
`endif
    prod = 35'(beats) * 35'(beat_len);
    // A halved beat could fall below the gap; keep at least one tone cycle.
    dur_load = (prod > 35'(GAP)) ? 32'(prod - 35'(GAP)) : 32'd1;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (stop) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (start_ok) state_nx = S_LOAD;
        S_LOAD: begin
          if (is_end)
            state_nx = loop_en ? S_LOAD : S_DONE;
          else
            state_nx = S_PLAY;
        end
        S_PLAY: if (dur_cnt <= 32'd1) state_nx = S_GAP;
        S_GAP:  if (gap_cnt <= 32'd1) state_nx = S_LOAD;
        S_DONE: state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy                  = (state == S_LOAD) || (state == S_PLAY) || (state == S_GAP);
    done                  = (state == S_DONE);
    audio.write_audio_out = audio.audio_out_allowed & busy;
  end

  assign audio.sample = sample_q;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      song        <= 2'd0;
      note_idx    <= 5'd0;
      half_period <= 20'd0;
      tone_cnt    <= 20'd0;
      phase       <= 1'b0;
      dur_cnt     <= 32'd0;
      gap_cnt     <= 32'd0;
      sample_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            song     <= song_sel;
            note_idx <= 5'd0;
          end
        end
        S_LOAD: begin
          if (is_end) begin
            if (loop_en) note_idx <= 5'd0;
          end else begin
            half_period <= load_hp;
            tone_cnt    <= 20'd0;
            phase       <= 1'b1;
            dur_cnt     <= dur_load;
            sample_q    <= (load_hp != 20'd0) ? AMP_POS : '0;
          end
        end
        S_PLAY: begin
          dur_cnt <= dur_cnt - 32'd1;
          if (half_period != 20'd0) begin
            if (tone_cnt == half_period - 20'd1) begin
              tone_cnt <= 20'd0;
              phase    <= ~phase;
              sample_q <= phase ? AMP_NEG : AMP_POS;
            end else begin
              tone_cnt <= tone_cnt + 20'd1;
            end
          end
          if (dur_cnt <= 32'd1) begin
            sample_q <= '0;
            gap_cnt  <= GAP;
          end
        end
        S_GAP: begin
          gap_cnt <= gap_cnt - 32'd1;
          if (gap_cnt <= 32'd1) note_idx <= note_idx + 5'd1;
        end
        S_DONE: begin
          note_idx    <= 5'd0;
          half_period <= 20'd0;
        end
        default: ;
      endcase
      // Abort overrides whatever the state above scheduled.
      if (stop) begin
        note_idx    <= 5'd0;
        half_period <= 20'd0;
        tone_cnt    <= 20'd0;
        phase       <= 1'b0;
        dur_cnt     <= 32'd0;
        gap_cnt     <= 32'd0;
        sample_q    <= '0;
      end
    end
  end

endmodule
